// File: rtl/elastic_pipe_buf.sv
// Elastic ready/valid buffer: DEPTH-entry circular store with fully registered
// handshake status, synchronous flush, fill level, almost-full and optional
// zero-word filtering with a saturating drop counter.
module elastic_pipe_buf #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter bit          DROP_ZERO = 1'b0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic [15:0]                drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);
  localparam logic [LW-1:0] LvlAf   = LW'(AF_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic accept, push, pop, drop;

  // Handshake status decoded from registered state only (plus flush gating).
  always_comb begin
    in_ready    = (level_q != LvlFull) & ~flush;
    out_valid   = (level_q != '0) & ~flush;
    out_data    = mem_q[rd_ptr_q];
    level       = level_q;
    almost_full = (level_q >= LvlAf);
    drop_cnt    = drop_cnt_q;
    accept      = in_valid & in_ready;
    drop        = accept & DROP_ZERO & (in_data == '0);
    push        = accept & ~drop;
    pop         = out_valid & out_ready;
  end

  // Next-state for storage, pointers, level and drop counter.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      // Contents stay in place; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // State registers; reset clears everything including storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
